// File: rtl/fpga_rst_seq.sv
// Reset sequencer behind the FPGA PLL: synchronises lock, releases poreset_n then hreset_n,
// and stretches system-reset requests. Optional lock-loss monitor: FPGA_RST_LOCKMON_EN.
module fpga_rst_seq #(
  parameter int unsigned LOCK_CYCLES  = 1024,
  parameter int unsigned PORST_GAP    = 16,
  parameter int unsigned SWRST_CYCLES = 64
) (
  input  logic       fclk,
  input  logic       reset_n,
  input  logic [1:0] pll_locked,
  input  logic       sys_reset_req,
  output logic       poreset_n,
  output logic       hreset_n,
  output logic       lock_lost,
  output logic [2:0] rst_state
);

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    POR_REL     = 3'd2,
    RUN         = 3'd3,
    SYS_RST     = 3'd4
  } state_t;

  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 32'd1);
  localparam logic [15:0] GAP_LAST   = 16'(PORST_GAP - 32'd1);
  localparam logic [15:0] SWRST_LAST = 16'(SWRST_CYCLES - 32'd1);

  logic [1:0]  sync1_r;
  logic [1:0]  sync2_r;
  logic        locked_sync_s;
  logic        lock_drop_s;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic        por_nxt_s;
  logic        hrst_nxt_s;
  logic        lost_nxt_s;

  // Two-flop synchroniser per lock bit
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= pll_locked;
      sync2_r <= sync1_r;
    end
  end

  assign locked_sync_s = &sync2_r;

`ifdef FPGA_RST_LOCKMON_EN
  assign lock_drop_s = ~locked_sync_s;
`else
  assign lock_drop_s = 1'b0;
`endif

  // Next state, shared counter and next output values
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    por_nxt_s   = poreset_n;
    hrst_nxt_s  = hreset_n;
    lost_nxt_s  = lock_lost;
    case (state_r)
      WAIT_LOCK: begin
        cnt_nxt_s  = 16'd0;
        por_nxt_s  = 1'b0;
        hrst_nxt_s = 1'b0;
        if (locked_sync_s) begin
          state_nxt_s = LOCK_STABLE;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      LOCK_STABLE: begin
        if (!locked_sync_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = 16'd0;
        end else if (cnt_r == LOCK_LAST) begin
          state_nxt_s = POR_REL;
          cnt_nxt_s   = 16'd0;
          por_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      POR_REL: begin
        if (lock_drop_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = 16'd0;
          por_nxt_s   = 1'b0;
          hrst_nxt_s  = 1'b0;
          lost_nxt_s  = 1'b1;
        end else if (cnt_r == GAP_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 16'd0;
          hrst_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      RUN: begin
        cnt_nxt_s = 16'd0;
        if (lock_drop_s) begin
          state_nxt_s = WAIT_LOCK;
          por_nxt_s   = 1'b0;
          hrst_nxt_s  = 1'b0;
          lost_nxt_s  = 1'b1;
        end else if (sys_reset_req) begin
          state_nxt_s = SYS_RST;
          hrst_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = RUN;
        end
      end
      SYS_RST: begin
        // Counter saturates so a long request is simply waited out
        if (lock_drop_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = 16'd0;
          por_nxt_s   = 1'b0;
          hrst_nxt_s  = 1'b0;
          lost_nxt_s  = 1'b1;
        end else if ((cnt_r == SWRST_LAST) && !sys_reset_req) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 16'd0;
          hrst_nxt_s  = 1'b1;
        end else if (cnt_r != SWRST_LAST) begin
          cnt_nxt_s = cnt_r + 16'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = 16'd0;
        por_nxt_s   = 1'b0;
        hrst_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= WAIT_LOCK;
      cnt_r     <= 16'd0;
      poreset_n <= 1'b0;
      hreset_n  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      poreset_n <= por_nxt_s;
      hreset_n  <= hrst_nxt_s;
      lock_lost <= lost_nxt_s;
    end
  end

  assign rst_state = state_r;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Bench for fpga_rst_seq: deadline-based reference model checked every cycle, plus
// hand-computed edge counts for release, pulse widths, lock glitch and async reset.
module tb_fpga_rst_seq;

  localparam int L = 1024;
  localparam int G = 16;
  localparam int S = 64;
`ifdef FPGA_RST_LOCKMON_EN
  localparam bit LOCKMON = 1'b1;
`else
  localparam bit LOCKMON = 1'b0;
`endif

  logic       fclk = 1'b0;
  logic       reset_n;
  logic [1:0] pll_locked;
  logic       sys_reset_req;
  logic       poreset_n;
  logic       hreset_n;
  logic       lock_lost;
  logic [2:0] rst_state;
  logic [5:0] outs;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  fpga_rst_seq #(.LOCK_CYCLES(L), .PORST_GAP(G), .SWRST_CYCLES(S)) dut (
    .fclk(fclk), .reset_n(reset_n), .pll_locked(pll_locked),
    .sys_reset_req(sys_reset_req), .poreset_n(poreset_n), .hreset_n(hreset_n),
    .lock_lost(lock_lost), .rst_state(rst_state)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) edge_n <= edge_n + 1;
  assign outs = {poreset_n, hreset_n, lock_lost, rst_state};

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: phase plus absolute edge deadlines
  logic [1:0] mq;
  int  m_ph, t_por, t_h, t_min;
  logic m_por, m_h, m_lost;
  int  nx_ph, nx_tp, nx_th, nx_tm;
  logic nx_por, nx_h, nx_lost;
  logic ls;
  int  n;

  always_comb begin
    nx_ph = m_ph; nx_tp = t_por; nx_th = t_h; nx_tm = t_min;
    nx_por = m_por; nx_h = m_h; nx_lost = m_lost;
    ls = mq[1];
    n = edge_n + 1;
    if (LOCKMON && !ls && m_ph >= 2 && m_ph <= 4) begin
      nx_ph = 0; nx_por = 1'b0; nx_h = 1'b0; nx_lost = 1'b1;
    end else begin
      case (m_ph)
        0: if (ls) begin nx_ph = 1; nx_tp = n + L; end
        1: if (!ls) nx_ph = 0;
           else if (n == t_por) begin nx_ph = 2; nx_por = 1'b1; nx_th = n + G; end
        2: if (n == t_h) begin nx_ph = 3; nx_h = 1'b1; end
        3: if (sys_reset_req) begin nx_ph = 4; nx_h = 1'b0; nx_tm = n + S; end
        4: if (n >= t_min && !sys_reset_req) begin nx_ph = 3; nx_h = 1'b1; end
        default: nx_ph = 0;
      endcase
    end
  end

  always @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      mq <= 2'b00; m_ph <= 0; m_por <= 1'b0; m_h <= 1'b0; m_lost <= 1'b0;
      t_por <= 0; t_h <= 0; t_min <= 0;
    end else begin
      mq <= {mq[0], &pll_locked};
      m_ph <= nx_ph; t_por <= nx_tp; t_h <= nx_th; t_min <= nx_tm;
      m_por <= nx_por; m_h <= nx_h; m_lost <= nx_lost;
    end
  end

  logic [5:0] m_outs;
  assign m_outs = {m_por, m_h, m_lost, 3'(m_ph)};

  always @(negedge fclk) check("outputs", int'(outs), int'(m_outs));

  // Edge numbers of reset transitions, observed mid-cycle
  logic por_d = 1'b0, h_d = 1'b0;
  int por_rise = 0, por_fall = 0, h_rise = 0, h_fall = 0;
  always @(negedge fclk) begin
    por_d <= poreset_n;
    h_d   <= hreset_n;
    if (poreset_n && !por_d) por_rise <= edge_n;
    if (!poreset_n && por_d) por_fall <= edge_n;
    if (hreset_n && !h_d) h_rise <= edge_n;
    if (!hreset_n && h_d) h_fall <= edge_n;
  end

  task automatic wait_state(input int s, input int budget, input string nm);
    int k;
    k = 0;
    while (int'(rst_state) != s && k < budget) begin
      @(negedge fclk);
      k++;
    end
    check(nm, int'(rst_state), s);
  endtask

  task automatic wait_h_high(input int budget, input string nm);
    int k;
    k = 0;
    while (!hreset_n && k < budget) begin
      @(negedge fclk);
      k++;
    end
    check(nm, int'(hreset_n), 1);
  endtask

  int e1, e2, d1;

  initial begin
    reset_n = 1'b0; pll_locked = 2'b00; sys_reset_req = 1'b0;
    repeat (3) @(negedge fclk);
    check("reset_values", int'(outs), 0);
    reset_n = 1'b1;

    // Power-up: both lock bits rise together
    @(negedge fclk);
    pll_locked = 2'b11; e1 = edge_n + 1;
    wait_state(3, 1200, "first_run_timeout");
    @(negedge fclk);
    check("por_release_edge", por_rise - e1 + 1, 1027);
    check("hrst_release_edge", h_rise - e1 + 1, 1043);
    check("state_run", int'(rst_state), 3);

    // One-cycle system-reset request
    @(negedge fclk); sys_reset_req = 1'b1;
    @(negedge fclk); sys_reset_req = 1'b0;
    wait_h_high(200, "short_req_timeout");
    @(negedge fclk);
    check("short_req_low_cycles", h_rise - h_fall, 64);
    check("por_held_short", int'(poreset_n), 1);

    // Request sampled high on 101 consecutive edges
    @(negedge fclk); sys_reset_req = 1'b1;
    repeat (101) @(negedge fclk);
    sys_reset_req = 1'b0;
    wait_h_high(200, "long_req_timeout");
    @(negedge fclk);
    check("long_req_low_cycles", h_rise - h_fall, 101);
    check("por_held_long", int'(poreset_n), 1);

    // Lock bit 0 drops while running
    @(negedge fclk); pll_locked = 2'b10; d1 = edge_n + 1;
    repeat (4) @(negedge fclk);
    if (LOCKMON) begin
      check("lost_flag", int'(lock_lost), 1);
      check("lost_resets", int'({poreset_n, hreset_n}), 0);
      check("lost_latency", por_fall - d1, 2);
      pll_locked = 2'b11;
      wait_state(3, 1200, "relock_timeout");
      check("lost_sticky", int'(lock_lost), 1);
    end else begin
      check("nolockmon_unchanged", int'(outs), int'({1'b1, 1'b1, 1'b0, 3'd3}));
      pll_locked = 2'b11;
    end

    // Lock glitch at LOCK_STABLE cnt=500, with a request that must be ignored
    @(negedge fclk); reset_n = 1'b0; pll_locked = 2'b00;
    @(negedge fclk); reset_n = 1'b1;
    @(negedge fclk); pll_locked = 2'b11; e1 = edge_n + 1;
    while (edge_n < e1 + 502) begin
      @(negedge fclk);
      if (edge_n == e1 + 100) sys_reset_req = 1'b1;
      if (edge_n == e1 + 110) sys_reset_req = 1'b0;
    end
    check("stable_before_glitch", int'(rst_state), 1);
    pll_locked = 2'b01;
    @(negedge fclk); pll_locked = 2'b11; e2 = edge_n + 1;
    repeat (2) @(negedge fclk);
    check("glitch_restart", int'(rst_state), 0);
    wait_state(3, 1200, "glitch_run_timeout");
    @(negedge fclk);
    check("glitch_por_edge", por_rise - e2 + 1, 1027);

    // Asynchronous reset in the middle of POR_REL
    @(negedge fclk); reset_n = 1'b0;
    @(negedge fclk); reset_n = 1'b1;
    wait_state(2, 1200, "porrel_timeout");
    repeat (5) @(negedge fclk);
    @(posedge fclk); #2 reset_n = 1'b0;
    #1 check("async_in_porrel", int'(outs), 0);
    @(negedge fclk); reset_n = 1'b1; e1 = edge_n + 1;
    wait_state(3, 1200, "restart1_timeout");
    @(negedge fclk);
    check("restart_por_edge", por_rise - e1 + 1, 1027);

    // Asynchronous reset in the middle of SYS_RST
    @(negedge fclk); sys_reset_req = 1'b1;
    repeat (10) @(negedge fclk);
    check("in_sysrst", int'(rst_state), 4);
    @(posedge fclk); #2 reset_n = 1'b0;
    #1 check("async_in_sysrst", int'(outs), 0);
    sys_reset_req = 1'b0;
    @(negedge fclk); reset_n = 1'b1; e1 = edge_n + 1;
    wait_state(3, 1200, "restart2_timeout");
    @(negedge fclk);
    check("restart2_hrst_edge", h_rise - e1 + 1, 1043);

    repeat (3) @(negedge fclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
